// File: rtl/lsu_mem_pkg.sv
// rtl/lsu_mem_pkg.sv - shared types, constants and helpers for the LSU data memory responder
package lsu_mem_pkg;

    // Width of the per-entry age counter; RESP_LAT must stay below 2**AGE_W.
    localparam int AGE_W = 8;

    // Fibonacci LFSR taps 16,14,13,11 expressed as a mask over lfsr[15:0].
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One queued response: captured data, error flag and cycles since grant.
    typedef struct packed {
        logic [31:0]      rdata;
        logic             err;
        logic [AGE_W-1:0] age;
    } resp_entry_t;

    // Number of bits needed to index a RAM of the given word count.
    function automatic int word_idx_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/lsu_data_mem_responder_if.sv
// rtl/lsu_data_mem_responder_if.sv - LSU data-side request/response bus with master and slave views
interface lsu_data_mem_responder_if #(
    parameter int MAX_OUTSTANDING = 2
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic             data_req_i;
    logic [31:0]      data_addr_i;
    logic             data_we_i;
    logic [3:0]       data_be_i;
    logic [31:0]      data_wdata_i;
    logic             data_gnt_o;
    logic             data_rvalid_o;
    logic [31:0]      data_rdata_o;
    logic             data_err_o;
    logic [CNT_W-1:0] outstanding_o;

    modport master (
        output data_req_i,
        output data_addr_i,
        output data_we_i,
        output data_be_i,
        output data_wdata_i,
        input  data_gnt_o,
        input  data_rvalid_o,
        input  data_rdata_o,
        input  data_err_o,
        input  outstanding_o
    );

    modport slave (
        input  data_req_i,
        input  data_addr_i,
        input  data_we_i,
        input  data_be_i,
        input  data_wdata_i,
        output data_gnt_o,
        output data_rvalid_o,
        output data_rdata_o,
        output data_err_o,
        output outstanding_o
    );

endinterface

// File: rtl/lsu_mem_resp_fifo.sv
// rtl/lsu_mem_resp_fifo.sv - in-order response queue with per-entry age counters
module lsu_mem_resp_fifo
    import lsu_mem_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int LAT   = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         i_push,
    input  logic [31:0]                  i_push_rdata,
    input  logic                         i_push_err,
    input  logic                         i_pop,
    output logic [31:0]                  o_head_rdata,
    output logic                         o_head_err,
    output logic                         o_head_ready,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [AGE_W-1:0] LAT_A    = AGE_W'(LAT);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    resp_entry_t      r_entries [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    resp_entry_t w_head;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !w_empty;
    assign w_head  = r_entries[r_rd_ptr];

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Entry storage; the age written at push is 1 because the grant cycle itself has elapsed
    // by the time the entry is visible, so age equals cycles since grant (saturating at LAT).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (r_wr_ptr == PTR_W'(i))) begin
                    r_entries[i].rdata <= i_push_rdata;
                    r_entries[i].err   <= i_push_err;
                    r_entries[i].age   <= AGE_W'(1);
                end else if (r_entries[i].age < LAT_A) begin
                    r_entries[i].age <= r_entries[i].age + 1'b1;
                end
            end
        end
    end

    assign o_head_rdata = w_head.rdata;
    assign o_head_err   = w_head.err;
    assign o_head_ready = !w_empty && (w_head.age >= LAT_A);
    assign o_count      = r_count;

endmodule

// File: rtl/lsu_data_mem_responder.sv
// rtl/lsu_data_mem_responder.sv - LSU data memory slave; random grant stalls under LSU_MEM_RAND_STALL_EN
module lsu_data_mem_responder
    import lsu_mem_pkg::*;
#(
    parameter int          MEM_WORDS       = 1024,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          RESP_LAT        = 1,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    lsu_data_mem_responder_if.slave bus
);

    localparam int IDX_W = word_idx_w(MEM_WORDS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [30:0]      WORDS_L = 31'(MEM_WORDS);

    logic [31:0]      r_ram [MEM_WORDS];

    logic [29:0]      w_word;
    logic             w_in_range;
    logic [IDX_W-1:0] w_idx;
    logic             w_stall;
    logic             w_hold;
    logic             w_gnt;
    logic             w_accept;
    logic             w_rvalid;
    logic [31:0]      w_push_rdata;
    logic [31:0]      w_head_rdata;
    logic             w_head_err;
    logic             w_head_ready;
    logic [CNT_W-1:0] w_count;
    logic             w_unused;

`ifdef LSU_MEM_RAND_STALL_EN
    logic [15:0] r_lfsr;

    // Free-running stall LFSR, shifted every cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
        end
    end

    assign w_stall  = (r_lfsr[1:0] == 2'b00);
    assign w_hold   = (r_lfsr[3:2] == 2'b00);
    assign w_unused = ^bus.data_addr_i[1:0];
`else
    assign w_stall  = 1'b0;
    assign w_hold   = 1'b0;
    assign w_unused = ^{bus.data_addr_i[1:0], LFSR_SEED};
`endif

    // Address decode: byte offset is ignored, anything past the RAM is a bus error.
    assign w_word     = bus.data_addr_i[31:2];
    assign w_in_range = ({1'b0, w_word} < WORDS_L);
    assign w_idx      = w_word[IDX_W-1:0];

    // Grant looks only at the registered occupancy, so a pop never frees a slot the same cycle.
    assign w_gnt    = rst_ni && bus.data_req_i && (w_count < MAX_CNT) && !w_stall;
    assign w_accept = bus.data_req_i && w_gnt;

    // Reads are captured at accept so later writes cannot alter a queued response.
    assign w_push_rdata = (w_in_range && !bus.data_we_i) ? r_ram[w_idx] : 32'h0;

    // Byte-enabled RAM write at the end of the accept cycle; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (w_accept && bus.data_we_i && w_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.data_be_i[b]) begin
                    r_ram[w_idx][8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    lsu_mem_resp_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .LAT   (RESP_LAT)
    ) u_resp_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .i_push       (w_accept),
        .i_push_rdata (w_push_rdata),
        .i_push_err   (!w_in_range),
        .i_pop        (w_rvalid),
        .o_head_rdata (w_head_rdata),
        .o_head_err   (w_head_err),
        .o_head_ready (w_head_ready),
        .o_count      (w_count)
    );

    assign w_rvalid = w_head_ready && !w_hold;

    assign bus.data_gnt_o    = w_gnt;
    assign bus.data_rvalid_o = w_rvalid;
    assign bus.data_rdata_o  = w_rvalid ? w_head_rdata : 32'h0;
    assign bus.data_err_o    = w_rvalid && w_head_err;
    assign bus.outstanding_o = w_count;

endmodule
